inst_cache: RTL and testbench
=============================

# inst_cache

Parametrised direct-mapped instruction cache that replaces the flat instruction ROM in the IF stage of the MIPS pipeline. A hit returns the instruction combinationally in the same cycle, with the same IF-stage timing as a flat ROM. A miss raises a stall request to the pipeline controller and refills one whole line from a backing memory over a simple req/ack port. A flush input invalidates every line, for program reload and self-modifying code.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width.
- `DATA_W`, 32, instruction width.
- `LINE_WORDS`, 4, words per line; power of two, ≥2.
- `LINES`, 16, number of lines; power of two, ≥2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `ce`  in  1  chip enable (`ChipEnable` = active).
- `addr`  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- `flush`  in  1  invalidate all lines.
- `inst`  out  DATA_W  fetched instruction.
- `stall_req`  out  1  pipeline must hold PC and IF/ID.
- `mem_req`  out  1  refill beat request.
- `mem_addr`  out  ADDR_W  word-aligned refill beat address.
- `mem_ack`  in  1  beat complete; meaningful only while `mem_req`=1.
- `mem_rdata`  in  DATA_W  beat data, valid with `mem_ack`.

## Operation
- Address split, from the LSB up:
  - [1:0] byte (ignored).
  - OFF = log2(LINE_WORDS) word offset.
  - IDX = log2(LINES) index.
  - Remaining upper bits: tag.
- Arrays: data[LINES×LINE_WORDS], tag[LINES], valid[LINES].
- Hit = `ce` & valid[idx] & tag[idx]==addr tag & state IDLE.
  - `inst` = data word on hit.
  - `inst` = `ZeroWord` on a miss, when `ce` is inactive, or in any non-IDLE state.
- `stall_req` = `ce` & !hit & !`rst`, plus 1 in every non-IDLE state.
- FSM states:
  - IDLE: on a miss with `ce` active, latch the line base address (offset zeroed) and go to REFILL. The `stall_req` of the miss cycle is combinational.
  - REFILL:
    - `mem_req`=1 and `mem_addr`=base+4·beat.
    - On `mem_ack`: write `mem_rdata` into data[idx][beat] and increment beat.
    - On the ack of the last beat: write the tag, set valid (unless poisoned, see `flush` below), and return to IDLE.
- Beats are strictly sequential with one outstanding; `mem_req` stays high between beats.
- Refill uses the latched index/tag. Changes to `addr` during REFILL are ignored, and lookup repeats in IDLE.
- `flush` = 1: all valid bits are cleared at the edge.
  - Flush during REFILL completes the line's data beats but does not set valid (poisoned). The line misses again afterwards.
  - Flush and the last-beat ack in the same cycle: the line is left invalid.
- Conflict miss: the refill overwrites the indexed line unconditionally.
- Reset mid-refill aborts immediately:
  - state IDLE, `mem_req`=0, all valid cleared.
  - Any in-flight ack after reset is ignored.

## Timing
- Reset values:
  - `inst`=`ZeroWord`, `stall_req`=0, `mem_req`=0, `mem_addr`=0.
  - state IDLE, beat=0, valid all 0.
- Hit latency: 0 cycles (combinational from `addr`).
- Miss, zero-wait memory (`mem_ack` asserted in the cycle `mem_req` rises):
  - cycle 0: miss detected.
  - cycles 1..LINE_WORDS: beats.
  - cycle LINE_WORDS+1: hit, `stall_req`=0.
  - Penalty: LINE_WORDS+1 stall cycles.
- Each wait cycle on `mem_ack` adds one cycle per beat.
- `mem_addr` advances on the edge after an ack.

## Structure
- Add to macros.v:
  - `InstCacheIdle` and `InstCacheRefill` state encodings.
  - Reuse `InstAddrBus`, `InstBus`, `ZeroWord`, `ChipEnable`.
- Sub-module `inst_cache_data_ram`:
  - LINES×LINE_WORDS×DATA_W array.
  - One combinational read port and one synchronous write port.
- Tag, valid and FSM live in the top module.

## Test plan
- Cold miss, `addr`=0x00000010, zero-wait memory returning word=address:
  - `stall_req` high for 5 cycles.
  - `mem_addr` sequence 0x10, 0x14, 0x18, 0x1C.
  - Then `inst`=0x00000010 with `stall_req`=0.
  - Then `addr`=0x1C hits immediately with `inst`=0x1C.
- Conflict: fill 0x010, then access 0x110 (same index, LINES=16).
  - 0x110 refills.
  - A return to 0x010 misses again.
- `ce` inactive with a miss address: `inst`=0, `stall_req`=0, `mem_req` never rises.
- Flush:
  - After filling 0x10, pulse `flush`; the next access to 0x10 misses.
  - Flush asserted during beat 2 of a refill: all 4 beats still complete, and the following access misses.
- Reset asserted during beat 1: next cycle `mem_req`=0, `stall_req` follows lookup, and a re-access refills from beat 0.
- Memory with 2 wait cycles per beat: stall length 13 cycles for LINE_WORDS=4; data is correct on each beat.

Source files
------------

// File: rtl/inst_cache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// Imported by the cache top and its data RAM.
package inst_cache_pkg;

    localparam logic CHIP_ENABLE = 1'b1;

    typedef enum logic {
        INST_CACHE_IDLE   = 1'b0,
        INST_CACHE_REFILL = 1'b1
    } cache_state_e;

endpackage

// File: rtl/inst_cache_data_ram.sv
// Instruction cache data array.
// One combinational read port and one synchronous write port.
module inst_cache_data_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache for the IF stage: combinational hit,
// stalled line refill over a req/ack port, and whole-cache flush.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int LINES      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [ADDR_W-1:0] addr,
    input  logic              flush,
    output logic [DATA_W-1:0] inst,
    output logic              stall_req,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

    logic [OFF_W-1:0] a_off;
    logic [IDX_W-1:0] a_idx;
    logic [TAG_W-1:0] a_tag;
    logic             unused_byte;

    assign a_off       = addr[2 +: OFF_W];
    assign a_idx       = addr[2+OFF_W +: IDX_W];
    assign a_tag       = addr[ADDR_W-1 -: TAG_W];
    assign unused_byte = ^addr[1:0];

    cache_state_e     state_q, state_d;
    logic [OFF_W-1:0] beat_q;
    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    logic             poison_q;
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [LINES];

    logic              idle;
    logic              refill;
    logic              hit;
    logic              miss;
    logic              beat_ack;
    logic              last_beat;
    logic [DATA_W-1:0] rd_data;

    assign idle      = (state_q == INST_CACHE_IDLE);
    assign refill    = (state_q == INST_CACHE_REFILL);
    assign hit       = (ce == CHIP_ENABLE) && idle && valid_q[a_idx]
                       && (tag_q[a_idx] == a_tag);
    assign miss      = (ce == CHIP_ENABLE) && idle && !hit;
    // an ack that lands in the reset cycle must not touch the array
    assign beat_ack  = refill && mem_ack && !rst;
    assign last_beat = &beat_q;

    inst_cache_data_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (LINES * LINE_WORDS)
    ) u_data_ram (
        .clk   (clk),
        .we    (beat_ack),
        .waddr ({r_idx, beat_q}),
        .wdata (mem_rdata),
        .raddr ({a_idx, a_off}),
        .rdata (rd_data)
    );

    always_comb begin
        state_d   = state_q;
        inst      = '0;
        stall_req = 1'b0;
        mem_req   = 1'b0;
        mem_addr  = '0;
        unique case (state_q)
            INST_CACHE_IDLE: begin
                if (hit) begin
                    inst = rd_data;
                end
                if (miss) begin
                    stall_req = 1'b1;
                    state_d   = INST_CACHE_REFILL;
                end
            end
            INST_CACHE_REFILL: begin
                stall_req = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = {r_tag, r_idx, beat_q, 2'b00};
                if (mem_ack && last_beat) begin
                    state_d = INST_CACHE_IDLE;
                end
            end
            default: state_d = INST_CACHE_IDLE;
        endcase
        if (rst) begin
            state_d   = INST_CACHE_IDLE;
            inst      = '0;
            stall_req = 1'b0;
            mem_req   = 1'b0;
            mem_addr  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= INST_CACHE_IDLE;
            beat_q   <= '0;
            poison_q <= 1'b0;
            valid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (miss) begin
                r_idx    <= a_idx;
                r_tag    <= a_tag;
                beat_q   <= '0;
                poison_q <= 1'b0;
            end
            if (beat_ack) begin
                beat_q <= beat_q + 1'b1;
                if (last_beat) begin
                    tag_q[r_idx] <= r_tag;
                end
            end
            // a flush mid-refill leaves the line being filled invalid
            if (flush) begin
                valid_q <= '0;
                if (refill) begin
                    poison_q <= 1'b1;
                end
            end else if (beat_ack && last_beat && !poison_q) begin
                valid_q[r_idx] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// Directed self-checking bench for inst_cache with a word=address memory
// model and a programmable number of wait cycles per beat.
module tb_inst_cache;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [31:0] addr;
    logic        flush;
    logic [31:0] inst;
    logic        stall_req;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int          wait_n;
    int          wcnt;
    int          n_checks;
    int          n_fail;
    logic [31:0] seen [$];

    inst_cache #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .LINE_WORDS (4),
        .LINES      (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .addr      (addr),
        .flush     (flush),
        .inst      (inst),
        .stall_req (stall_req),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        mem_ack   = mem_req && (wcnt == wait_n);
        mem_rdata = mem_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt <= 0;
        end else if (mem_req && !mem_ack) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_access(input logic [31:0] a, output int stalls);
        bit done;
        addr   = a;
        ce     = 1'b1;
        stalls = 0;
        done   = 0;
        seen.delete();
        for (int i = 0; i < 80 && !done; i++) begin
            #1;
            if (!stall_req) begin
                done = 1;
            end else begin
                stalls++;
                if (mem_req && mem_ack) seen.push_back(mem_addr);
                cyc();
            end
        end
        if (!done) check("stall_timeout", 32'd1, 32'd0);
    endtask

    int   st;
    logic req_seen;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        wait_n   = 0;
        rst      = 1'b1;
        ce       = 1'b0;
        addr     = 32'h0;
        flush    = 1'b0;
        cyc();
        ce   = 1'b1;
        addr = 32'h10;
        #1;
        check("rst_inst", inst, 32'h0);
        check("rst_stall", {31'b0, stall_req}, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        cyc();
        rst = 1'b0;
        ce  = 1'b0;
        cyc();

        run_access(32'h10, st);
        check("cold_stalls", st, 32'd5);
        check("cold_beats", seen.size(), 32'd4);
        for (int i = 0; i < 4 && i < seen.size(); i++)
            check("cold_mem_addr", seen[i], 32'h10 + 4 * i);
        check("cold_inst", inst, 32'h10);
        run_access(32'h1C, st);
        check("hit_stalls", st, 32'd0);
        check("hit_inst", inst, 32'h1C);

        run_access(32'h110, st);
        check("conf_stalls", st, 32'd5);
        check("conf_inst", inst, 32'h110);
        run_access(32'h010, st);
        check("conf_back_stalls", st, 32'd5);
        check("conf_back_inst", inst, 32'h10);

        ce       = 1'b0;
        addr     = 32'h200;
        req_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ce_off_inst", inst, 32'h0);
            check("ce_off_stall", {31'b0, stall_req}, 32'd0);
            req_seen = req_seen | mem_req;
            cyc();
        end
        check("ce_off_mem_req", {31'b0, req_seen}, 32'd0);

        run_access(32'h10, st);
        check("pre_flush_hit", st, 32'd0);
        ce    = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        run_access(32'h10, st);
        check("flush_stalls", st, 32'd5);
        check("flush_inst", inst, 32'h10);

        addr = 32'h40;
        ce   = 1'b1;
        #1;
        check("mf_miss_stall", {31'b0, stall_req}, 32'd1);
        cyc();
        cyc();
        cyc();
        check("mf_beat2_addr", mem_addr, 32'h48);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        run_access(32'h40, st);
        check("mf_stalls", st, 32'd6);
        check("mf_beats", seen.size(), 32'd5);
        if (seen.size() > 1) begin
            check("mf_last_beat", seen[0], 32'h4C);
            check("mf_refetch", seen[1], 32'h40);
        end
        check("mf_inst", inst, 32'h40);

        addr = 32'h80;
        ce   = 1'b1;
        #1;
        cyc();
        cyc();
        check("rr_beat1_addr", mem_addr, 32'h84);
        rst = 1'b1;
        #1;
        check("rr_rst_mem_req", {31'b0, mem_req}, 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        check("rr_idle_mem_req", {31'b0, mem_req}, 32'd0);
        check("rr_idle_stall", {31'b0, stall_req}, 32'd1);
        run_access(32'h80, st);
        check("rr_stalls", st, 32'd5);
        if (seen.size() > 0) check("rr_first_beat", seen[0], 32'h80);
        check("rr_inst", inst, 32'h80);
        run_access(32'h40, st);
        check("rr_valid_cleared", st, 32'd5);

        wait_n = 2;
        run_access(32'hC0, st);
        check("wait_stalls", st, 32'd13);
        check("wait_beats", seen.size(), 32'd4);
        for (int i = 0; i < 4 && i < seen.size(); i++)
            check("wait_mem_addr", seen[i], 32'hC0 + 4 * i);
        check("wait_inst", inst, 32'hC0);
        run_access(32'hCC, st);
        check("wait_hit_stalls", st, 32'd0);
        check("wait_hit_inst", inst, 32'hCC);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
